// File: rtl/rom_port_arbiter.sv
// ============================================================================
// rom_port_arbiter : shares one synchronous-read ROM between fetch (I) and
//                    load (D) ports; ROM_ARB_RR_EN selects round-robin.
// Revision 1.0
// ============================================================================
`default_nettype none

module rom_port_arbiter #(
  parameter int ROM_WORDS = 32,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  input  logic        i_flush_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_rerr_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_rerr_o,
  output logic [31:0] rom_a_o,
  input  logic [31:0] rom_rd_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(ROM_WORDS * 4);

  owner_e      owner_q, owner_d;
  logic        err_q, err_d;
  logic [31:0] rom_a_q, rom_a_d;
  logic        i_win, d_win;
  logic [31:0] win_addr;

`ifdef ROM_ARB_RR_EN
  logic        last_d_q, last_d_d;  // 1 when D holds the most recent grant
`else
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  logic [3:0]  wait_q, wait_d;
`endif

  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (!rst_i) begin
      if (i_req_i && d_req_i) begin
`ifdef ROM_ARB_RR_EN
        i_win = last_d_q;
        d_win = !last_d_q;
`else
        i_win = (wait_q == WAIT_MAX);
        d_win = !i_win;
`endif
      end else begin
        i_win = i_req_i;
        d_win = d_req_i;
      end
    end
  end

  always_comb begin
    owner_d  = OWN_NONE;
    err_d    = 1'b0;
    rom_a_d  = rom_a_q;
    win_addr = d_win ? d_addr_i : i_addr_i;
    if (i_win) begin
      owner_d = OWN_I;
    end else if (d_win) begin
      owner_d = OWN_D;
    end
    // Bad accesses still take the slot; the ROM word read is simply discarded.
    if (i_win || d_win) begin
      rom_a_d = {win_addr[31:2], 2'b00};
      err_d   = (win_addr[1:0] != 2'b00) || (win_addr >= ADDR_LIMIT);
    end
`ifdef ROM_ARB_RR_EN
    last_d_d = last_d_q;
    if (i_win) begin
      last_d_d = 1'b0;
    end else if (d_win) begin
      last_d_d = 1'b1;
    end
`else
    wait_d = wait_q;
    if (!i_req_i || i_win) begin
      wait_d = 4'd0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 4'd1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      rom_a_q  <= 32'd0;
`ifdef ROM_ARB_RR_EN
      last_d_q <= 1'b0;
`else
      wait_q   <= 4'd0;
`endif
    end else begin
      owner_q  <= owner_d;
      err_q    <= err_d;
      rom_a_q  <= rom_a_d;
`ifdef ROM_ARB_RR_EN
      last_d_q <= last_d_d;
`else
      wait_q   <= wait_d;
`endif
    end
  end

  assign i_gnt_o = i_win;
  assign d_gnt_o = d_win;
  assign rom_a_o = rom_a_d;

  // Reset kills any response still in flight.
  assign i_rvalid_o = !rst_i && (owner_q == OWN_I) && !i_flush_i;
  assign i_rerr_o   = i_rvalid_o && err_q;
  assign i_rdata_o  = (i_rvalid_o && !err_q) ? rom_rd_i : 32'd0;

  assign d_rvalid_o = !rst_i && (owner_q == OWN_D);
  assign d_rerr_o   = d_rvalid_o && err_q;
  assign d_rdata_o  = (d_rvalid_o && !err_q) ? rom_rd_i : 32'd0;

endmodule

`default_nettype wire
